// File: rtl/quire_normalizer.sv
// Converts a two's-complement quire word into posit field form (sign, scale, fraction,
// guard, sticky, zero, NaR) through a three-stage abs / leading-zero / shift pipeline.
module quire_normalizer #(
   parameter int POSIT_WIDTH     = 8,
   parameter int POSIT_ES        = 0,
   parameter int LOG_NB_ACCUM    = 15,
   parameter int QUIRE_WIDTH     = (2 ** (POSIT_ES + 2)) * (POSIT_WIDTH - 2) + 2 + LOG_NB_ACCUM,
   parameter int QUIRE_FRAC_BITS = (2 ** (POSIT_ES + 1)) * (POSIT_WIDTH - 2),
   parameter int FRAC_OUT_WIDTH  = POSIT_WIDTH,
   parameter int SCALE_OUT_WIDTH = $clog2(QUIRE_WIDTH) + 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              rts_i,
   output logic                              rtr_o,
   input  logic                              sow_i,
   input  logic                              eow_i,
   input  logic [QUIRE_WIDTH-1:0]            data_i,
   input  logic                              rtr_i,
   output logic                              rts_o,
   output logic                              sow_o,
   output logic                              eow_o,
   output logic                              sign_o,
   output logic                              zero_o,
   output logic                              NaR_o,
   output logic signed [SCALE_OUT_WIDTH-1:0] scale,
   output logic [FRAC_OUT_WIDTH-1:0]         fraction,
   output logic                              guard_o,
   output logic                              sticky_o
);

   localparam int MW    = QUIRE_WIDTH - 1;
   localparam int LZC_W = $clog2(QUIRE_WIDTH);

   // Handshake: a word moves on a clock edge where its valid (rts) and the receiver's
   // ready (rtr) are both high. The whole pipe advances together whenever the output
   // register is empty or being drained, so rtr_o is combinational from rtr_i.
   logic advance;
   assign advance = rtr_i | ~rts_o;
   assign rtr_o   = advance;

   // stage 1: classify and take magnitude
   logic          v1, sow1, eow1, sign1, zero1, nar1;
   logic [MW-1:0] mag1;
   // stage 2: leading-zero count
   logic             v2, sow2, eow2, sign2, zero2, nar2;
   logic [MW-1:0]    mag2;
   logic [LZC_W-1:0] lzc2;

   logic [QUIRE_WIDTH-1:0] neg_data;
   logic                   nar_in, zero_in;
   assign neg_data = -data_i;
   assign nar_in   = (data_i == {1'b1, {MW{1'b0}}});
   assign zero_in  = (data_i == '0);

   function automatic logic [LZC_W-1:0] count_lz(input logic [MW-1:0] v);
      logic [LZC_W-1:0] n;
      logic             found;
      n     = '0;
      found = 1'b0;
      for (int i = MW - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + LZC_W'(1);
         end
      end
      return n;
   endfunction

   // stage 3 next-state: the shift by lzc+1 pushes the hidden bit out of the top
   logic [LZC_W:0]                  shamt;
   logic [MW-1:0]                   shifted;
   int                              scale_int;
   logic signed [SCALE_OUT_WIDTH-1:0] scale_n;
   logic [FRAC_OUT_WIDTH-1:0]       frac_n;
   logic                            guard_n, sticky_n, special;

   always_comb begin
      shamt     = {1'b0, lzc2} + (LZC_W + 1)'(1);
      shifted   = mag2 << shamt;
      scale_int = QUIRE_WIDTH - 2 - int'(lzc2) - QUIRE_FRAC_BITS;
      special   = zero2 | nar2;
      scale_n   = '0;
      frac_n    = '0;
      guard_n   = 1'b0;
      sticky_n  = 1'b0;
      if (!special) begin
         scale_n  = scale_int[SCALE_OUT_WIDTH-1:0];
         frac_n   = shifted[MW-1 -: FRAC_OUT_WIDTH];
         guard_n  = shifted[MW-1-FRAC_OUT_WIDTH];
         sticky_n = |shifted[MW-2-FRAC_OUT_WIDTH:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0; sow1 <= 1'b0; eow1 <= 1'b0;
         sign1 <= 1'b0; zero1 <= 1'b0; nar1 <= 1'b0; mag1 <= '0;
         v2 <= 1'b0; sow2 <= 1'b0; eow2 <= 1'b0;
         sign2 <= 1'b0; zero2 <= 1'b0; nar2 <= 1'b0; mag2 <= '0; lzc2 <= '0;
         rts_o <= 1'b0; sow_o <= 1'b0; eow_o <= 1'b0;
         sign_o <= 1'b0; zero_o <= 1'b0; NaR_o <= 1'b0;
         scale <= '0; fraction <= '0; guard_o <= 1'b0; sticky_o <= 1'b0;
      end else if (advance) begin
         v1    <= rts_i;
         sow1  <= sow_i;
         eow1  <= eow_i;
         sign1 <= data_i[QUIRE_WIDTH-1];
         zero1 <= zero_in;
         nar1  <= nar_in;
         mag1  <= data_i[QUIRE_WIDTH-1] ? neg_data[MW-1:0] : data_i[MW-1:0];

         v2    <= v1;
         sow2  <= sow1;
         eow2  <= eow1;
         sign2 <= sign1;
         zero2 <= zero1;
         nar2  <= nar1;
         mag2  <= mag1;
         lzc2  <= count_lz(mag1);

         rts_o    <= v2;
         sow_o    <= sow2;
         eow_o    <= eow2;
         sign_o   <= sign2 & ~zero2;
         zero_o   <= zero2;
         NaR_o    <= nar2;
         scale    <= scale_n;
         fraction <= frac_n;
         guard_o  <= guard_n;
         sticky_o <= sticky_n;
      end
   end

endmodule
